// File: rtl/fft_stage_sequencer.sv
// Stage/address sequencer for an iterative radix-2 DIT FFT, driving the one-hot stage ring.
// Optional `FFT_SEQ_ABORT_EN adds i_ABORT to cancel a transform from any non-IDLE state.
module fft_stage_sequencer #(
  parameter int N_LOG2     = 4,
  parameter int BF_LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              i_START,
  input  logic              i_BF_READY,
`ifdef FFT_SEQ_ABORT_EN
  input  logic              i_ABORT,
`endif
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_BF_VALID,
  output logic [N_LOG2-1:0] o_ADDR_A,
  output logic [N_LOG2-1:0] o_ADDR_B,
  output logic [N_LOG2-2:0] o_TW_ADDR,
  output logic              o_STAGE_EN,
  output logic              o_STAGE_RST
);
  localparam int KW = N_LOG2 - 1;
  localparam int SW = $clog2(N_LOG2 + 1);
  localparam int DW = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [KW-1:0]     K_LAST = '1;
  localparam logic [KW-1:0]     K_ONE  = KW'(1);
  localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
  localparam logic [SW-1:0]     S_ONE  = SW'(1);
  localparam logic [DW-1:0]     D_LAST = DW'(BF_LATENCY - 1);
  localparam logic [DW-1:0]     D_ONE  = DW'(1);
  localparam logic [N_LOG2-1:0] A_ONE  = N_LOG2'(1);

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [KW-1:0]     k_q, k_d;
  logic [DW-1:0]     d_q, d_d;
  logic              busy_q, done_q, valid_q, sen_q, srst_q;
  logic [N_LOG2-1:0] a_q, b_q;
  logic [N_LOG2-2:0] tw_q;
  logic [N_LOG2-1:0] kx, span, pos, a_n, b_n;
  logic [N_LOG2-2:0] tw_n;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    d_d     = d_q;
    case (state_q)
      IDLE: if (i_START) begin
        state_d = RUN;
        s_d     = '0;
        k_d     = '0;
      end
      RUN: if (i_BF_READY) begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
          d_d     = '0;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      DRAIN: if (d_q == D_LAST) begin
        if (s_q == S_LAST) state_d = DONE;
        else begin
          state_d = RUN;
          s_d     = s_q + S_ONE;
        end
      end else begin
        d_d = d_q + D_ONE;
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
      end
    endcase
`ifdef FFT_SEQ_ABORT_EN
    if (i_ABORT && state_q != IDLE) begin
      state_d = IDLE;
      s_d     = '0;
      k_d     = '0;
      d_d     = '0;
    end
`endif
  end

  // Addresses are precomputed from next-state s/k so the ports are plain flops.
  always_comb begin
    kx   = {1'b0, k_d};
    span = A_ONE << s_d;
    pos  = kx & (span - A_ONE);
    a_n  = ((kx >> s_d) << (s_d + S_ONE)) | pos;
    b_n  = a_n | span;
    tw_n = pos[N_LOG2-2:0] << (S_LAST - s_d);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      sen_q   <= 1'b0;
      srst_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      d_q     <= d_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      valid_q <= (state_d == RUN);
      srst_q  <= (state_q == IDLE) && (state_d == RUN);
      // Last stage has no successor, so the ring is left alone there.
      sen_q   <= (state_q == RUN) && (state_d == DRAIN) && (s_q != S_LAST);
      a_q     <= (state_d == RUN) ? a_n  : '0;
      b_q     <= (state_d == RUN) ? b_n  : '0;
      tw_q    <= (state_d == RUN) ? tw_n : '0;
    end
  end

  assign o_BUSY      = busy_q;
  assign o_DONE      = done_q;
  assign o_BF_VALID  = valid_q;
  assign o_ADDR_A    = a_q;
  assign o_ADDR_B    = b_q;
  assign o_TW_ADDR   = tw_q;
  assign o_STAGE_EN  = sen_q;
  assign o_STAGE_RST = srst_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: transfer-order monitor with arithmetic address model.
module tb_fft_stage_sequencer;
  localparam int N_LOG2     = 4;
  localparam int BF_LATENCY = 2;
  localparam int HALF       = 1 << (N_LOG2 - 1);
  localparam int TOTAL      = N_LOG2 * HALF;
  localparam int RUN_CYC    = N_LOG2 * (HALF + BF_LATENCY);

  logic CLK = 1'b0, RST_N = 1'b0, i_START = 1'b0, i_BF_READY = 1'b0;
`ifdef FFT_SEQ_ABORT_EN
  logic i_ABORT = 1'b0;
`endif
  logic o_BUSY, o_DONE, o_BF_VALID, o_STAGE_EN, o_STAGE_RST;
  logic [N_LOG2-1:0] o_ADDR_A, o_ADDR_B;
  logic [N_LOG2-2:0] o_TW_ADDR;
  int checks = 0, failures = 0;

  fft_stage_sequencer #(.N_LOG2(N_LOG2), .BF_LATENCY(BF_LATENCY)) dut (
    .CLK(CLK), .RST_N(RST_N), .i_START(i_START), .i_BF_READY(i_BF_READY),
`ifdef FFT_SEQ_ABORT_EN
    .i_ABORT(i_ABORT),
`endif
    .o_BUSY(o_BUSY), .o_DONE(o_DONE), .o_BF_VALID(o_BF_VALID),
    .o_ADDR_A(o_ADDR_A), .o_ADDR_B(o_ADDR_B), .o_TW_ADDR(o_TW_ADDR),
    .o_STAGE_EN(o_STAGE_EN), .o_STAGE_RST(o_STAGE_RST)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(o_BUSY), 0);
    chk({tag, "_done"},  32'(o_DONE), 0);
    chk({tag, "_valid"}, 32'(o_BF_VALID), 0);
    chk({tag, "_sen"},   32'(o_STAGE_EN), 0);
    chk({tag, "_srst"},  32'(o_STAGE_RST), 0);
    chk({tag, "_a"},     32'(o_ADDR_A), 0);
    chk({tag, "_b"},     32'(o_ADDR_B), 0);
    chk({tag, "_tw"},    32'(o_TW_ADDR), 0);
  endtask

  // mode 0: READY high, 1: random READY, 2: READY low 3 cycles at s=2,k=2
  task automatic run_xform(input int mode, input bit poke_start);
    int idx = 0, gap = 0, cyc = 0, first = -1, done_at = -1, en_cnt = 0, vcnt = 0, hold = 0;
    int es, ek, span, pos, ea;
    bit rdy;
    i_START = 1'b1;
    step();
    i_START = 1'b0;
    chk("stage_rst_first", 32'(o_STAGE_RST), 1);
    while (done_at < 0 && cyc < 2000) begin
      if (cyc > 0) chk("stage_rst_once", 32'(o_STAGE_RST), 0);
      chk("en_rst_excl", 32'(o_STAGE_EN & o_STAGE_RST), 0);
      chk("busy", 32'(o_BUSY), 1);
      if (o_STAGE_EN) en_cnt++;
      if (o_BF_VALID) begin
        if (first < 0) first = cyc;
        if (gap != 0) begin
          chk("drain_len", gap, BF_LATENCY);
          gap = 0;
        end
        es = idx / HALF; ek = idx % HALF;
        span = 1 << es; pos = ek % span;
        ea = (ek / span) * 2 * span + pos;
        chk("addr_a", 32'(o_ADDR_A), ea);
        chk("addr_b", 32'(o_ADDR_B), ea + span);
        chk("tw", 32'(o_TW_ADDR), pos * (HALF / span));
        chk("run_sen", 32'(o_STAGE_EN), 0);
        if (idx == 5) begin
          chk("s0k5_a", 32'(o_ADDR_A), 10); chk("s0k5_b", 32'(o_ADDR_B), 11); chk("s0k5_tw", 32'(o_TW_ADDR), 0);
        end
        if (idx == HALF + 3) begin
          chk("s1k3_a", 32'(o_ADDR_A), 5); chk("s1k3_b", 32'(o_ADDR_B), 7); chk("s1k3_tw", 32'(o_TW_ADDR), 4);
        end
        if (idx == 2 * HALF + 2) begin
          chk("s2k2_a", 32'(o_ADDR_A), 2); chk("s2k2_b", 32'(o_ADDR_B), 6); chk("s2k2_tw", 32'(o_TW_ADDR), 4);
        end
        if (idx == 3 * HALF + 7) begin
          chk("s3k7_a", 32'(o_ADDR_A), 7); chk("s3k7_b", 32'(o_ADDR_B), 15); chk("s3k7_tw", 32'(o_TW_ADDR), 7);
        end
        vcnt++;
        case (mode)
          0: rdy = 1'b1;
          1: rdy = ($urandom_range(0, 3) != 0);
          default: begin
            rdy = !(idx == 2 * HALF + 2 && hold < 3);
            if (!rdy) hold++;
          end
        endcase
        i_BF_READY = rdy;
        if (rdy) idx++;
      end else if (o_DONE) begin
        done_at = cyc;
        chk("done_gap", gap, BF_LATENCY);
        chk("done_xfers", idx, TOTAL);
      end else begin
        gap++;
        chk("drain_sen", 32'(o_STAGE_EN), 32'(gap == 1 && idx < TOTAL));
        chk("drain_boundary", idx % HALF, 0);
        i_BF_READY = 1'($urandom_range(0, 1));
      end
      i_START = poke_start && ($urandom_range(0, 3) == 0 || o_DONE);
      cyc++;
      step();
    end
    chk("done_seen", 32'(done_at >= 0), 1);
    i_START = 1'b0;
    i_BF_READY = 1'b0;
    chk_idle("after_done");
    step();
    chk_idle("after_done2");
    chk("stage_en_count", en_cnt, N_LOG2 - 1);
    if (mode == 0) begin
      chk("done_latency", done_at - first, RUN_CYC);
      chk("valid_cycles", vcnt, TOTAL);
    end
    if (mode == 2) begin
      chk("bp_latency", done_at - first, RUN_CYC + 3);
      chk("bp_valid_cycles", vcnt, TOTAL + 3);
    end
  endtask

  initial begin
    #12;
    chk_idle("reset");
    @(negedge CLK) RST_N = 1'b1;
    step();
    chk_idle("idle_after_rst");

    // Reset asserted in the middle of a transform
    i_START = 1'b1;
    step();
    i_START = 1'b0;
    i_BF_READY = 1'b1;
    repeat (4) step();
    chk("pre_rst_valid", 32'(o_BF_VALID), 1);
    RST_N = 1'b0;
    #1;
    chk_idle("async_rst");
    step();
    chk_idle("rst_hold");
    @(negedge CLK) RST_N = 1'b1;
    i_BF_READY = 1'b0;
    step();
    chk_idle("post_rst_idle");

    run_xform(0, 1'b1);
    run_xform(1, 1'b0);
    run_xform(1, 1'b1);
    run_xform(2, 1'b0);

`ifdef FFT_SEQ_ABORT_EN
    begin
      int dones = 0;
      i_START = 1'b1;
      step();
      i_START = 1'b0;
      i_BF_READY = 1'b1;
      repeat (2 * (HALF + BF_LATENCY) - BF_LATENCY) step();
      chk("abort_in_drain", 32'(o_BF_VALID), 0);
      chk("abort_busy", 32'(o_BUSY), 1);
      i_ABORT = 1'b1;
      step();
      i_ABORT = 1'b0;
      chk_idle("abort");
      repeat (RUN_CYC + 5) begin
        step();
        if (o_DONE || o_BUSY) dones++;
      end
      chk("abort_no_done", dones, 0);
      i_START = 1'b1;
      i_ABORT = 1'b1;
      step();
      i_START = 1'b0;
      i_ABORT = 1'b0;
      chk("start_beats_abort", 32'(o_BUSY), 1);
      chk("start_beats_abort_rst", 32'(o_STAGE_RST), 1);
      i_ABORT = 1'b1;
      step();
      i_ABORT = 1'b0;
      chk_idle("abort_run");
      run_xform(0, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
